// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, bus FSM states,
// byte-mask generation, lane replication and load-data extraction.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } fsm_e;

  // Size code 3 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << a;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sext,
                                           input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (size)
      SZ_B:    return sext ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      SZ_H:    return sext ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sb_fifo.sv
// Circular store buffer: push/pop in one cycle each, zero-latency head and match outputs.
// No internal backpressure: the owner must not push when full or pop when empty.
module lsu_sb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_waddr,
  input  logic [3:0]             push_mask,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  input  logic [AW-1:0]          match_waddr,
  output logic [AW-1:0]          head_waddr,
  output logic [3:0]             head_mask,
  output logic [31:0]            head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       match_vec,
  output logic                   y_hit,
  output logic [3:0]             y_mask,
  output logic [31:0]            y_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] waddr_q [DEPTH];
  logic [AW-1:0] waddr_d [DEPTH];
  logic [3:0]    mask_q  [DEPTH];
  logic [3:0]    mask_d  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [31:0]   data_d  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] y_idx;
  logic [PW-1:0] off;

  always_comb begin
    waddr_d  = waddr_q;
    mask_d   = mask_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      waddr_d[wr_ptr_q] = push_waddr;
      mask_d[wr_ptr_q]  = push_mask;
      data_d[wr_ptr_q]  = push_data;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Walk slots oldest-to-youngest so the last hit seen is the youngest matching entry.
  always_comb begin
    match_vec = '0;
    y_hit     = 1'b0;
    y_idx     = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      match_vec[i] = ({1'b0, off} < count_q) && (waddr_q[i] == match_waddr);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (match_vec[rd_ptr_q + PW'(k)]) begin
        y_hit = 1'b1;
        y_idx = rd_ptr_q + PW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        mask_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      waddr_q  <= waddr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_waddr = waddr_q[rd_ptr_q];
  assign head_mask  = mask_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign y_mask     = mask_q[y_idx];
  assign y_data     = data_q[y_idx];

endmodule

// File: rtl/lsu_stb_unit.sv
// Load/store unit with posted store buffer; store/misalign rsp 1 cycle after accept, bus loads >=2, forwarded loads 1 (LSU_STB_FWD_EN).
// Backpressure: req_ready drops while a load is held or in flight, and for stores when the buffer is full.
module lsu_stb_unit
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [3:0]        daccess_ren,
  output logic [ADDR_W-1:0] daccess_addr,
  input  logic              daccess_valid,
  input  logic [31:0]       daccess_rdata,
  output logic [3:0]        daccess_wen,
  output logic [31:0]       daccess_wdata,
  input  logic              daccess_wresp,
  output logic              sb_empty
);

  localparam int CW = $clog2(SB_DEPTH) + 1;
  localparam int WA = ADDR_W - 2;
`ifdef LSU_STB_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  fsm_e              state_q, state_d;
  logic              ld_held_q, ld_held_d, ld_sext_q, ld_sext_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [3:0]        ren_q, ren_d, wen_q, wen_d, need_mask, head_mask, y_mask;
  logic [ADDR_W-1:0] daddr_q, daddr_d, ld_addr_cur;
  logic [WA-1:0]     head_waddr;
  logic [31:0]       head_data, y_data;
  logic [CW-1:0]     sb_count;
  logic [SB_DEPTH-1:0] match_vec;
  logic y_hit, accept, mis, st_acc, ld_acc, fwd_hit, ld_pend, conflict;
  logic issue_ld, issue_st, pop, rd_done;

  always_comb begin
    req_ready   = !ld_held_q && (state_q != LD_WAIT) && !(req_wr && sb_count == CW'(SB_DEPTH));
    accept      = req_valid && req_ready;
    mis         = accept && misaligned(req_size, req_addr[1:0]);
    st_acc      = accept && req_wr && !mis;
    ld_acc      = accept && !req_wr && !mis;
    need_mask   = byte_mask(req_size, req_addr[1:0]);
    // Only the youngest matching entry is a safe forwarding source.
    fwd_hit     = FWD_EN && ld_acc && y_hit && ((y_mask & need_mask) == need_mask);
    ld_pend     = ld_held_q || (ld_acc && !fwd_hit);
    ld_addr_cur = ld_held_q ? ld_addr_q : req_addr;
    conflict    = |match_vec;
    issue_ld    = (state_q == IDLE) && ld_pend && !conflict;
    issue_st    = (state_q == IDLE) && !issue_ld && (sb_count != '0);
    pop         = (state_q == ST_WAIT) && daccess_wresp;
    rd_done     = (state_q == LD_WAIT) && daccess_valid;
    ld_held_d   = ld_pend && !issue_ld;
    ld_addr_d   = ld_acc ? req_addr : ld_addr_q;
    ld_size_d   = ld_acc ? req_size : ld_size_q;
    ld_sext_d   = ld_acc ? req_sext : ld_sext_q;
  end

  lsu_sb_fifo #(.DEPTH(SB_DEPTH), .AW(WA)) u_sb (
    .clk        (cpu_clk),
    .rst_n      (cpu_rstn),
    .push       (st_acc),
    .push_waddr (req_addr[ADDR_W-1:2]),
    .push_mask  (need_mask),
    .push_data  (lane_rep(req_size, req_wdata)),
    .pop        (pop),
    .match_waddr(ld_addr_cur[ADDR_W-1:2]),
    .head_waddr (head_waddr),
    .head_mask  (head_mask),
    .head_data  (head_data),
    .count      (sb_count),
    .match_vec  (match_vec),
    .y_hit      (y_hit),
    .y_mask     (y_mask),
    .y_data     (y_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_ld)      state_d = LD_WAIT;
        else if (issue_st) state_d = ST_WAIT;
      end
      LD_WAIT: if (daccess_valid) state_d = IDLE;
      ST_WAIT: if (daccess_wresp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ren_d       = 4'h0;
    wen_d       = 4'h0;
    daddr_d     = daddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    if (issue_ld) begin
      ren_d   = 4'hF;
      daddr_d = {ld_addr_cur[ADDR_W-1:2], 2'b00};
    end else if (issue_st) begin
      wen_d   = head_mask;
      wdata_d = head_data;
      daddr_d = {head_waddr, 2'b00};
    end
    // Accepts and bus read returns never coincide: req_ready is low in LD_WAIT.
    if (mis) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end else if (st_acc) begin
      rsp_valid_d = 1'b1;
    end else if (fwd_hit) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = load_ext(req_size, req_sext, req_addr[1:0], y_data);
    end else if (rd_done) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = load_ext(ld_size_q, ld_sext_q, ld_addr_q[1:0], daccess_rdata);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= IDLE;
      ld_held_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_size_q   <= 2'b00;
      ld_sext_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      ren_q       <= 4'h0;
      wen_q       <= 4'h0;
      daddr_q     <= '0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      ld_held_q   <= ld_held_d;
      ld_addr_q   <= ld_addr_d;
      ld_size_q   <= ld_size_d;
      ld_sext_q   <= ld_sext_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      daddr_q     <= daddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign daccess_ren   = ren_q;
  assign daccess_wen   = wen_q;
  assign daccess_addr  = daddr_q;
  assign daccess_wdata = wdata_q;
  assign sb_empty      = (sb_count == '0) && (state_q != ST_WAIT);

endmodule

// File: doc/lsu_stb_unit.md
Name: lsu_stb_unit

Overview:
- Parametrised load/store unit between the pipeline MEM stage and the data-access bus.
- Replaces the single-request, whole-pipeline-suspend MEM path.
- Stores are posted into an SB_DEPTH-entry store buffer that drains in the background.
- Loads bypass the buffer when addresses do not conflict; misaligned accesses are trapped locally without any bus traffic.

Parameters:
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2.
- ADDR_W, 32: request/bus address width.

Ports:
- cpu_clk  in  1  clock
- cpu_rstn  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage request valid
- req_ready  out  1  unit accepts request this cycle
- req_wr  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word (3 is illegal and treated as word)
- req_sext  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  misaligned access
- rsp_rdata  out  32  extended load data; 0 for stores/errors
- daccess_ren  out  4  4'hF one-cycle read request pulse
- daccess_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- daccess_valid  in  1  read data valid pulse
- daccess_rdata  in  32  read data
- daccess_wen  out  4  byte write mask pulse
- daccess_wdata  out  32  lane-aligned write data
- daccess_wresp  in  1  write response pulse
- sb_empty  out  1  store buffer empty and no store in flight

Behaviour:
- Reset: all outputs 0, except sb_empty=1 and req_ready=1. FSM=IDLE, buffer count 0, load register empty.
- Acceptance: a request is accepted on req_valid & req_ready.
- req_ready=0 while a load is held or in flight.
- req_ready=0 for stores when count==SB_DEPTH. Uses current count; no same-cycle pop bypass.
- Misalign:
  - half with addr[0]!=0 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - A misaligned request gets rsp_valid=1, rsp_err=1 the next cycle. No bus access, no buffer entry.
- Store accept:
  - Push {word addr, mask, lane data}. Mask: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'hF.
  - Data is replicated across lanes.
  - rsp_valid (err=0, rdata=0) the next cycle.
- Load accept: captured into the load register.
- Conflict: any valid buffer entry, or the in-flight store, has a word address equal to the load's word address.
- Bus FSM, states IDLE, LD_WAIT, ST_WAIT; registered request pulses; one bus transaction outstanding:
  - IDLE: a held load with no conflict has priority. Next cycle ren=4'hF pulse, go to LD_WAIT.
  - IDLE: otherwise, if count>0, issue a wen/wdata pulse for the head entry and go to ST_WAIT.
  - LD_WAIT: on daccess_valid, rsp_valid=1 next cycle with rdata = (rdata>>8*a[1:0]) extended per size/sext. Return to IDLE.
  - ST_WAIT: on daccess_wresp, pop head and return to IDLE.
- Conflicted load waits until all matching entries have drained (buffer order preserved).
- Minimum load latency: accept at T, ren at T+1, rsp at T+2 when the bus answers in the same cycle.
- daccess_addr holds the last issued address between pulses.
- Pointers wrap modulo SB_DEPTH. Push and pop in the same cycle leave count unchanged.
- Responses and bus pulses arriving in an unexpected state (e.g. after reset mid-transaction) are ignored.

Optional Feature:
- Macro LSU_STB_FWD_EN.
- Defined: on load accept, if the youngest matching entry's mask covers all requested bytes, the load completes from the buffer. rsp_valid the next cycle, no bus access, FSM not used; req_ready stays 1.
- Partial coverage falls back to the conflict wait.
- Undefined: no forwarding; every conflict waits for drain.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W
  - FSM state encoding
  - functions for byte-mask generation and load extension
- Sub-module lsu_sb_fifo: circular buffer with push/pop and per-entry word-address match vector plus youngest-match index.
- lsu_stb_unit holds the FSM, misalign check and lane steering.

Test Plan:
- Load word 0x100, bus returns 0x8899AABB the same cycle as ren -> rsp at T+2, rdata=0x8899AABB, ren high exactly one cycle.
- Load byte sext at 0x103, rdata 0x80000000 -> rsp_rdata=0xFFFFFF80; with req_sext=0 -> 0x00000080.
- Half store at 0x102, data 0x1234 -> rsp next cycle; later wen=4'b1100, wdata=0x12341234, addr 0x100; sb_empty rises after wresp.
- Five word stores with SB_DEPTH=4 and wresp withheld -> req_ready=0 on the fifth until the first wresp pops; drain order matches issue order.
- Store word 0x200 = 0xDEADBEEF, then load word 0x200 -> without macro, ren only after the store's wresp and data read from bus; with LSU_STB_FWD_EN, rsp next cycle with 0xDEADBEEF and no ren.
- Load word at 0x102 -> rsp_err=1 next cycle, no ren/wen. Reset asserted while in LD_WAIT -> outputs reset; a later daccess_valid produces no rsp.
